// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_ctrl
//  Summary  : Execute-stage branch sequencer. Holds one B-type branch, waits
//             for both operands, resolves the condition, checks it against
//             the front-end prediction and raises a held fetch redirect on a
//             mispredict. Keeps branch / mispredict performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             rs1_ready,
    input  logic             rs2_ready,
    input  logic             flush_in,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_illegal,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    input  logic             redirect_ready,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_OPS = 2'd1,
        S_RESOLVE  = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    localparam logic [6:0]      c_OPC_BRANCH = 7'b1100011;
    localparam logic [XLEN-1:0] c_PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [6:0]       r_opcode;
    logic [2:0]       r_funct3;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_imm;
    logic             r_pred_taken;
    logic [XLEN-1:0]  r_rs1;
    logic [XLEN-1:0]  r_rs2;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_perf_branches;
    logic [CNT_W-1:0] r_perf_mispredicts;

    logic             w_illegal;
    logic             w_cond;
    logic             w_taken;
    logic             w_mispredict;
    logic             w_res_fire;
    logic [XLEN-1:0]  w_target;

    // Condition evaluation on the held branch; an illegal branch never counts as taken.
    always_comb begin
        w_illegal = (r_opcode != c_OPC_BRANCH) || (r_funct3 == 3'b010) || (r_funct3 == 3'b011);
        w_cond    = 1'b0;
        case (r_funct3)
            3'b000:  w_cond = (r_rs1 == r_rs2);
            3'b001:  w_cond = (r_rs1 != r_rs2);
            3'b100:  w_cond = ($signed(r_rs1) <  $signed(r_rs2));
            3'b101:  w_cond = ($signed(r_rs1) >= $signed(r_rs2));
            3'b110:  w_cond = (r_rs1 <  r_rs2);
            3'b111:  w_cond = (r_rs1 >= r_rs2);
            default: w_cond = 1'b0;
        endcase
        w_taken      = w_cond && !w_illegal;
        w_mispredict = !w_illegal && (w_taken != r_pred_taken);
        // Both sums wrap modulo 2^XLEN by construction.
        w_target     = w_taken ? (r_pc + r_imm) : (r_pc + c_PC_STEP);
        // A flush in the resolve cycle kills the result and any side effects.
        w_res_fire   = (r_state == S_RESOLVE) && !flush_in;
    end

    assign in_ready         = (r_state == S_IDLE) && !flush_in;
    assign res_valid        = w_res_fire;
    assign res_taken        = w_res_fire && w_taken;
    assign res_illegal      = w_res_fire && w_illegal;
    assign redirect_valid   = (r_state == S_REDIRECT);
    assign redirect_pc      = r_redirect_pc;
    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;

    // Branch sequencing FSM with held branch fields, operands, redirect PC and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_opcode           <= '0;
            r_funct3           <= '0;
            r_pc               <= '0;
            r_imm              <= '0;
            r_pred_taken       <= 1'b0;
            r_rs1              <= '0;
            r_rs2              <= '0;
            r_redirect_pc      <= '0;
            r_perf_branches    <= '0;
            r_perf_mispredicts <= '0;
        end else if (flush_in) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_opcode     <= in_opcode;
                        r_funct3     <= in_funct3;
                        r_pc         <= in_pc;
                        r_imm        <= in_imm;
                        r_pred_taken <= in_pred_taken;
                        r_state      <= S_WAIT_OPS;
                    end
                end
                S_WAIT_OPS: begin
                    if (rs1_ready && rs2_ready) begin
                        r_rs1   <= rs1_data;
                        r_rs2   <= rs2_data;
                        r_state <= S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    r_state <= S_IDLE;
                    if (!w_illegal) begin
                        r_perf_branches <= r_perf_branches + c_CNT_ONE;
                        if (w_mispredict) begin
                            r_perf_mispredicts <= r_perf_mispredicts + c_CNT_ONE;
                            r_redirect_pc      <= w_target;
                            r_state            <= S_REDIRECT;
                        end
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolve_ctrl
//  Summary  : Self-checking bench for branch_resolve_ctrl. Directed scenarios
//             plus randomized branches compared with a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;

    localparam int XLEN  = 64;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_opcode;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_imm;
    logic             in_pred_taken;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             rs1_ready;
    logic             rs2_ready;
    logic             flush_in;
    logic             res_valid;
    logic             res_taken;
    logic             res_illegal;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             redirect_ready;
    logic [CNT_W-1:0] perf_branches;
    logic [CNT_W-1:0] perf_mispredicts;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_opcode        (in_opcode),
        .in_funct3        (in_funct3),
        .in_pc            (in_pc),
        .in_imm           (in_imm),
        .in_pred_taken    (in_pred_taken),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .rs1_ready        (rs1_ready),
        .rs2_ready        (rs2_ready),
        .flush_in         (flush_in),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_illegal      (res_illegal),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_ready   (redirect_ready),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model counters kept as plain integers; compared modulo 2^CNT_W.
    longint unsigned m_br = 0;
    longint unsigned m_mp = 0;

    localparam int F_NONE = 0, F_WAIT = 1, F_RESOLVE = 2, F_REDIRECT = 3, F_RESET = 4;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 4))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 3));
            default: return rnd64();
        endcase
    endfunction

    // Architectural meaning of a B-type branch, straight from the ISA rules.
    function automatic void ref_branch(
        input  logic [6:0]  opc,
        input  logic [2:0]  f3,
        input  logic [63:0] pc,
        input  logic [63:0] imm,
        input  logic [63:0] a,
        input  logic [63:0] b,
        input  logic        pred,
        output logic        legal,
        output logic        taken,
        output logic        mispred,
        output logic [63:0] tgt
    );
        longint sa, sb;
        longint unsigned ua, ub;
        sa = a; sb = b; ua = a; ub = b;
        legal = (opc == 7'b1100011) && (f3 != 3'd2) && (f3 != 3'd3);
        case (f3)
            3'd0:    taken = (ua == ub);
            3'd1:    taken = (ua != ub);
            3'd4:    taken = (sa < sb);
            3'd5:    taken = (sa >= sb);
            3'd6:    taken = (ua < ub);
            3'd7:    taken = (ua >= ub);
            default: taken = 1'b0;
        endcase
        if (!legal) taken = 1'b0;
        mispred = legal && (taken != pred);
        tgt     = taken ? (pc + imm) : (pc + 64'd4);
    endfunction

    task automatic quiet_inputs();
        in_valid       = 1'b0;
        in_opcode      = 7'($urandom());
        in_funct3      = 3'($urandom());
        in_pc          = rnd64();
        in_imm         = rnd64();
        in_pred_taken  = 1'($urandom());
        rs1_data       = rnd64();
        rs2_data       = rnd64();
        rs1_ready      = 1'b0;
        rs2_ready      = 1'b0;
        flush_in       = 1'b0;
        redirect_ready = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        logic [63:0] eb, em;
        eb = 64'(m_br[CNT_W-1:0]);
        em = 64'(m_mp[CNT_W-1:0]);
        check_eq({tag, "_perf_br"}, 64'(perf_branches), eb);
        check_eq({tag, "_perf_mp"}, 64'(perf_mispredicts), em);
    endtask

    // One branch through the controller. Each cycle: drive at negedge, check 1ns later.
    task automatic do_branch(
        input string       tag,
        input logic [6:0]  opc,
        input logic [2:0]  f3,
        input logic [63:0] pc,
        input logic [63:0] imm,
        input logic        pred,
        input logic [63:0] a,
        input logic [63:0] b,
        input int          wait_n,
        input int          rr_delay,
        input int          fault
    );
        logic legal, taken, mp;
        logic [63:0] tgt;
        ref_branch(opc, f3, pc, imm, a, b, pred, legal, taken, mp, tgt);

        // accept cycle
        @(negedge clk);
        quiet_inputs();
        in_valid = 1'b1; in_opcode = opc; in_funct3 = f3;
        in_pc = pc; in_imm = imm; in_pred_taken = pred;
        #1;
        check_eq({tag, "_accept_ready"}, 64'(in_ready), 64'd1);

        // operand wait: partial readiness only
        for (int i = 0; i < wait_n; i++) begin
            @(negedge clk);
            quiet_inputs();
            rs1_ready = 1'($urandom());
            rs2_ready = rs1_ready ? 1'b0 : 1'($urandom());
            #1;
            check_eq({tag, "_wait_resv"}, 64'(res_valid), 64'd0);
            check_eq({tag, "_wait_ready"}, 64'(in_ready), 64'd0);
        end

        // operands ready cycle
        @(negedge clk);
        quiet_inputs();
        rs1_ready = 1'b1; rs2_ready = 1'b1; rs1_data = a; rs2_data = b;
        if (fault == F_WAIT) flush_in = 1'b1;
        #1;
        check_eq({tag, "_ops_resv"}, 64'(res_valid), 64'd0);
        check_eq({tag, "_ops_ready"}, 64'(in_ready), 64'd0);
        if (fault == F_WAIT) begin
            @(negedge clk);
            quiet_inputs();
            #1;
            check_eq({tag, "_fw_ready"}, 64'(in_ready), 64'd1);
            check_eq({tag, "_fw_resv"}, 64'(res_valid), 64'd0);
            check_counters({tag, "_fw"});
            return;
        end

        // resolve cycle; operand buses now carry garbage
        @(negedge clk);
        quiet_inputs();
        if (fault == F_RESOLVE) flush_in = 1'b1;
        #1;
        if (fault == F_RESOLVE) begin
            check_eq({tag, "_fr_resv"}, 64'(res_valid), 64'd0);
            @(negedge clk);
            quiet_inputs();
            #1;
            check_eq({tag, "_fr_ready"}, 64'(in_ready), 64'd1);
            check_eq({tag, "_fr_resv2"}, 64'(res_valid), 64'd0);
            check_counters({tag, "_fr"});
            return;
        end
        check_eq({tag, "_resv"}, 64'(res_valid), 64'd1);
        check_eq({tag, "_taken"}, 64'(res_taken), 64'(taken));
        check_eq({tag, "_illegal"}, 64'(res_illegal), 64'(!legal));
        check_eq({tag, "_res_redir"}, 64'(redirect_valid), 64'd0);
        if (legal) m_br++;
        if (mp) m_mp++;

        if (!mp) begin
            @(negedge clk);
            quiet_inputs();
            #1;
            check_eq({tag, "_post_ready"}, 64'(in_ready), 64'd1);
            check_eq({tag, "_post_redir"}, 64'(redirect_valid), 64'd0);
            check_eq({tag, "_post_resv"}, 64'(res_valid), 64'd0);
            check_counters({tag, "_post"});
            return;
        end

        // redirect hold, handshake on cycle rr_delay
        for (int k = 0; k <= rr_delay; k++) begin
            @(negedge clk);
            quiet_inputs();
            if (k == rr_delay) begin
                if (fault == F_RESET) begin
                    reset = 1'b1;
                end else begin
                    redirect_ready = 1'b1;
                    if (fault == F_REDIRECT) flush_in = 1'b1;
                end
            end
            #1;
            check_eq({tag, "_rd_valid"}, 64'(redirect_valid), 64'd1);
            check_eq({tag, "_rd_pc"}, redirect_pc, tgt);
            check_eq({tag, "_rd_ready"}, 64'(in_ready), 64'd0);
            if (k == 0) check_counters({tag, "_rd"});
        end

        @(negedge clk);
        quiet_inputs();
        reset = 1'b0;
        if (fault == F_RESET) begin
            m_br = 0;
            m_mp = 0;
        end
        #1;
        check_eq({tag, "_done_redir"}, 64'(redirect_valid), 64'd0);
        check_eq({tag, "_done_ready"}, 64'(in_ready), 64'd1);
        check_counters({tag, "_done"});
        if (fault == F_RESET) check_eq({tag, "_rst_pc"}, redirect_pc, 64'd0);
    endtask

    localparam logic [6:0] OPC_B = 7'b1100011;

    initial begin
        logic [6:0] opc;
        int         fault;

        quiet_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_res_valid", 64'(res_valid), 64'd0);
        check_eq("rst_res_taken", 64'(res_taken), 64'd0);
        check_eq("rst_res_illegal", 64'(res_illegal), 64'd0);
        check_eq("rst_redir_valid", 64'(redirect_valid), 64'd0);
        check_eq("rst_redir_pc", redirect_pc, 64'd0);
        check_counters("rst");
        reset = 1'b0;

        // directed scenarios
        do_branch("beq", OPC_B, 3'd0, 64'h1000, 64'h20, 1'b1, 64'd5, 64'd5, 0, 0, F_NONE);
        do_branch("blt", OPC_B, 3'd4, 64'h2000, 64'h40, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, F_NONE);
        do_branch("bltu", OPC_B, 3'd6, 64'h2000, 64'h40, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, F_NONE);
        do_branch("bge_wrap", OPC_B, 3'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h80, 1'b1,
                  64'd0, 64'd1, 0, 3, F_NONE);
        do_branch("bne_wait", OPC_B, 3'd1, 64'h3000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0,
                  64'd7, 64'd9, 4, 1, F_NONE);
        do_branch("ill_f3", OPC_B, 3'd2, 64'h4000, 64'h10, 1'b1, 64'd1, 64'd1, 0, 0, F_NONE);
        do_branch("ill_opc", 7'b0110011, 3'd0, 64'h4000, 64'h10, 1'b1, 64'd1, 64'd1, 0, 0, F_NONE);
        do_branch("fl_wait", OPC_B, 3'd0, 64'h5000, 64'h8, 1'b0, 64'd3, 64'd3, 2, 0, F_WAIT);
        do_branch("fl_res", OPC_B, 3'd0, 64'h5000, 64'h8, 1'b0, 64'd3, 64'd3, 0, 0, F_RESOLVE);
        do_branch("fl_redir", OPC_B, 3'd7, 64'h6000, 64'h100, 1'b0, 64'd9, 64'd2, 0, 2, F_REDIRECT);

        // flush while presenting in IDLE: must not be accepted
        @(negedge clk);
        quiet_inputs();
        in_valid = 1'b1; in_opcode = OPC_B;
        flush_in = 1'b1;
        #1;
        check_eq("fl_idle_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        quiet_inputs();
        #1;
        check_eq("fl_idle_noacc", 64'(in_ready), 64'd1);

        do_branch("rst_mid", OPC_B, 3'd0, 64'h7000, 64'h44, 1'b1, 64'd1, 64'd2, 0, 1, F_RESET);

        // randomized branches
        for (int n = 0; n < 300; n++) begin
            opc   = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : OPC_B;
            fault = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : F_NONE;
            do_branch("rnd", opc, 3'($urandom()), rnd64(), rnd64(), 1'($urandom()),
                      rnd_op(), rnd_op(), $urandom_range(0, 3), $urandom_range(0, 3), fault);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
